// File: rtl/eth_phy_10g_rx_prbs31_checker.sv
// Receive-side PRBS31 checker for the 10G PHY SERDES interface.
// Self-synchronising: the history register is filled from the received
// stream itself, so no seed is needed. Every 66-bit block (hdr[0], hdr[1],
// data[0..63], bit 0 first on the line) is checked bit by bit. The checker
// reports the error bits per block, keeps a lock state machine and
// accumulates a saturating error count while locked.

module eth_phy_10g_rx_prbs31_checker #(
  parameter int   DATA_WIDTH    = 64,
  parameter int   HDR_WIDTH     = 2,
  parameter logic INVERT        = 1'b1,
  parameter int   LOCK_BLOCKS   = 64,
  parameter int   UNLOCK_BLOCKS = 16,
  parameter int   CNT_WIDTH     = 16
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst,
  input  logic                  cfg_enable,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic [HDR_WIDTH-1:0]  rx_hdr,
  input  logic                  rx_valid,
  input  logic                  err_clear,
  output logic                  prbs_locked,
  output logic                  block_err,
  output logic [6:0]            block_err_bits,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_count_sat
);

  localparam int BLK_WIDTH = DATA_WIDTH + HDR_WIDTH;
  localparam int POP_W     = 7;
  localparam int GOOD_W    = $clog2(LOCK_BLOCKS + 1);
  localparam int BAD_W     = $clog2(UNLOCK_BLOCKS + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // Stage 1 registers
  logic [DATA_WIDTH-1:0] data_s1_q, data_s1_d;
  logic [HDR_WIDTH-1:0]  hdr_s1_q, hdr_s1_d;
  logic                  valid_s1_q, valid_s1_d;
  logic                  en_s1_q, en_s1_d;
  logic                  clr_s1_q, clr_s1_d;

  // Stage 2 registers
  logic [30:0]           hist_q, hist_d;
  logic                  prime_q, prime_d;
  lock_state_t           state_q, state_d;
  logic [GOOD_W-1:0]     good_cnt_q, good_cnt_d;
  logic [BAD_W-1:0]      bad_cnt_q, bad_cnt_d;
  logic                  block_err_q, block_err_d;
  logic [POP_W-1:0]      block_err_bits_q, block_err_bits_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic                  err_count_sat_q, err_count_sat_d;

  // Stage 2 combinational results
  logic [BLK_WIDTH-1:0]  blk_bits;
  logic [BLK_WIDTH-1:0]  err_vec;
  logic [30:0]           hist_next;
  logic [POP_W-1:0]      err_pop;
  logic                  eval_blk;
  logic [POP_W-1:0]      cnt_inc;
  logic [CNT_WIDTH-1:0]  cnt_base;
  logic [CNT_WIDTH:0]    cnt_sum;

  // Enable and clear travel with the block so their effect lines up with
  // the block presented in the same cycle.
  always_comb begin
    data_s1_d  = rx_data;
    hdr_s1_d   = rx_hdr;
    valid_s1_d = rx_valid;
    en_s1_d    = cfg_enable;
    clr_s1_d   = err_clear;
  end

  // Stage 1 capture of the SERDES block and its qualifiers
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      data_s1_q  <= '0;
      hdr_s1_q   <= '0;
      valid_s1_q <= 1'b0;
      en_s1_q    <= 1'b0;
      clr_s1_q   <= 1'b0;
    end else begin
      data_s1_q  <= data_s1_d;
      hdr_s1_q   <= hdr_s1_d;
      valid_s1_q <= valid_s1_d;
      en_s1_q    <= en_s1_d;
      clr_s1_q   <= clr_s1_d;
    end
  end

  assign blk_bits = {data_s1_q, hdr_s1_q};

  // Unrolled per-bit check: predict each bit from taps 31 and 28 of the history
  always_comb begin
    logic [30:0] s;
    logic        d;
    s       = hist_q;
    d       = 1'b0;
    err_vec = '0;
    for (int i = 0; i < BLK_WIDTH; i++) begin
      d          = blk_bits[i] ^ INVERT;
      err_vec[i] = d ^ s[30] ^ s[27];
      s          = {s[29:0], d};
    end
    hist_next = s;
  end

  // Population count of the error bits of the block
  always_comb begin
    err_pop = '0;
    for (int i = 0; i < BLK_WIDTH; i++) begin
      err_pop = err_pop + {{(POP_W-1){1'b0}}, err_vec[i]};
    end
  end

  // Prime handling, lock state machine and per-block error reporting
  always_comb begin
    hist_d           = hist_q;
    prime_d          = prime_q;
    state_d          = state_q;
    good_cnt_d       = good_cnt_q;
    bad_cnt_d        = bad_cnt_q;
    block_err_d      = 1'b0;
    block_err_bits_d = '0;
    eval_blk         = 1'b0;
    if (!en_s1_q) begin
      state_d    = UNLOCKED;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      prime_d    = 1'b1;
    end else if (valid_s1_q) begin
      hist_d = hist_next;
      if (prime_q) begin
        prime_d = 1'b0;
      end else begin
        eval_blk         = 1'b1;
        block_err_d      = |err_vec;
        block_err_bits_d = err_pop;
        if (err_pop == '0) begin
          bad_cnt_d = '0;
          if (state_q == UNLOCKED) begin
            if (good_cnt_q == GOOD_W'(LOCK_BLOCKS - 1)) begin
              state_d    = LOCKED;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + GOOD_W'(1);
            end
          end
        end else begin
          good_cnt_d = '0;
          if (state_q == LOCKED) begin
            if (bad_cnt_q == BAD_W'(UNLOCK_BLOCKS - 1)) begin
              state_d   = UNLOCKED;
              bad_cnt_d = '0;
            end else begin
              bad_cnt_d = bad_cnt_q + BAD_W'(1);
            end
          end
        end
      end
    end
  end

  // Saturating error accumulator; a clear in the same cycle keeps the increment
  always_comb begin
    cnt_inc  = (eval_blk && (state_q == LOCKED)) ? err_pop : '0;
    cnt_base = clr_s1_q ? '0 : err_count_q;
    cnt_sum  = {1'b0, cnt_base} + {{(CNT_WIDTH+1-POP_W){1'b0}}, cnt_inc};
    if (cnt_sum >= {1'b0, CNT_MAX}) begin
      err_count_d     = CNT_MAX;
      err_count_sat_d = 1'b1;
    end else begin
      err_count_d     = cnt_sum[CNT_WIDTH-1:0];
      err_count_sat_d = clr_s1_q ? 1'b0 : err_count_sat_q;
    end
  end

  // Stage 2 state and registered outputs
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      hist_q           <= '0;
      prime_q          <= 1'b1;
      state_q          <= UNLOCKED;
      good_cnt_q       <= '0;
      bad_cnt_q        <= '0;
      block_err_q      <= 1'b0;
      block_err_bits_q <= '0;
      err_count_q      <= '0;
      err_count_sat_q  <= 1'b0;
    end else begin
      hist_q           <= hist_d;
      prime_q          <= prime_d;
      state_q          <= state_d;
      good_cnt_q       <= good_cnt_d;
      bad_cnt_q        <= bad_cnt_d;
      block_err_q      <= block_err_d;
      block_err_bits_q <= block_err_bits_d;
      err_count_q      <= err_count_d;
      err_count_sat_q  <= err_count_sat_d;
    end
  end

  assign prbs_locked    = (state_q == LOCKED);
  assign block_err      = block_err_q;
  assign block_err_bits = block_err_bits_q;
  assign err_count      = err_count_q;
  assign err_count_sat  = err_count_sat_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_prbs31_checker.sv
// Self-checking bench for eth_phy_10g_rx_prbs31_checker. A PRBS31 line
// generator feeds the checker, and a behavioural model computes the expected
// outputs of every input cycle. Those outputs are compared two cycles later,
// when the design presents them. Scenario checks against fixed constants
// cover lock timing, error multiplication, loss of lock, saturation, clear
// and enable handling.

module tb_eth_phy_10g_rx_prbs31_checker;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             rx_clk = 1'b0;
  logic             rx_rst;
  logic             cfg_enable;
  logic [63:0]      rx_data;
  logic [1:0]       rx_hdr;
  logic             rx_valid;
  logic             err_clear;
  logic             prbs_locked;
  logic             block_err;
  logic [6:0]       block_err_bits;
  logic [CNT_W-1:0] err_count;
  logic             err_count_sat;

  eth_phy_10g_rx_prbs31_checker #(
    .DATA_WIDTH(64), .HDR_WIDTH(2), .INVERT(1'b1),
    .LOCK_BLOCKS(64), .UNLOCK_BLOCKS(16), .CNT_WIDTH(CNT_W)
  ) dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .cfg_enable(cfg_enable),
    .rx_data(rx_data), .rx_hdr(rx_hdr), .rx_valid(rx_valid),
    .err_clear(err_clear), .prbs_locked(prbs_locked), .block_err(block_err),
    .block_err_bits(block_err_bits), .err_count(err_count),
    .err_count_sat(err_count_sat)
  );

  // Free-running receive clock, 10 time units per period
  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic             be;
    logic [6:0]       bits;
    logic             lk;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    int               idx;
  } exp_t;

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t pipe1, pipe2, zero_exp;
  int   blk_idx, rise_idx, fall_idx, err_pulses, obs_bits_sum;
  logic prev_lk;

  // Generator history (PRBS bits, oldest first) and model checker history
  bit g_q[$];
  bit m_hist[$];
  bit m_prime, m_locked, m_sat;
  int m_good, m_bad, m_cnt;

  // Counts one comparison and reports it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model of the checker after reset: empty history, priming pending, unlocked
  task automatic modelReset();
    m_hist.delete();
    for (int i = 0; i < 31; i++) m_hist.push_back(1'b0);
    m_prime = 1'b1; m_locked = 1'b0; m_sat = 1'b0;
    m_good = 0; m_bad = 0; m_cnt = 0;
    pipe1 = zero_exp; pipe2 = zero_exp;
    prev_lk = 1'b0;
  endtask

  // Next 66 line bits of the inverted PRBS31 pattern, bit 0 first on the line
  task automatic genBlock(output logic [65:0] line);
    bit p;
    for (int i = 0; i < 66; i++) begin
      p = g_q[0] ^ g_q[3];
      void'(g_q.pop_front());
      g_q.push_back(p);
      line[i] = p ^ 1'b1;
    end
  endtask

  // Expected outputs for one input cycle, from the checker's behavioural rules
  task automatic modelStep(input logic v, input logic en, input logic clr,
                           input logic [65:0] line, output exp_t e);
    int nbits, add;
    bit d, x;
    nbits = 0; add = 0;
    e.be = 1'b0; e.bits = '0; e.idx = 0;
    if (!en) begin
      m_locked = 1'b0; m_good = 0; m_bad = 0; m_prime = 1'b1;
    end else if (v) begin
      for (int i = 0; i < 66; i++) begin
        d = line[i] ^ 1'b1;
        x = d ^ m_hist[0] ^ m_hist[3];
        nbits += int'(x);
        void'(m_hist.pop_front());
        m_hist.push_back(d);
      end
      if (m_prime) begin
        m_prime = 1'b0;
      end else begin
        e.be   = (nbits != 0);
        e.bits = 7'(nbits);
        if (m_locked) add = nbits;
        if (nbits == 0) begin
          m_bad = 0;
          m_good++;
          if (!m_locked && m_good >= 64) begin m_locked = 1'b1; m_good = 0; end
        end else begin
          m_good = 0;
          if (m_locked) begin
            m_bad++;
            if (m_bad >= 16) begin m_locked = 1'b0; m_bad = 0; end
          end
        end
      end
    end
    if (clr) begin m_cnt = 0; m_sat = 1'b0; end
    m_cnt += add;
    if (m_cnt >= CNT_MAX) begin m_cnt = CNT_MAX; m_sat = 1'b1; end
    e.lk = m_locked; e.cnt = CNT_W'(m_cnt); e.sat = m_sat;
  endtask

  // Drives one input cycle and checks the outputs now due (two cycles latency)
  task automatic applyStimulus(input logic v, input logic en, input logic clr, input logic [65:0] line);
    exp_t e;
    rx_valid = v; cfg_enable = en; err_clear = clr;
    rx_hdr = line[1:0]; rx_data = line[65:2];
    if (v && en) blk_idx++;
    modelStep(v, en, clr, line, e);
    e.idx = blk_idx;
    @(posedge rx_clk); #1;
    pipe2 = pipe1; pipe1 = e;
    checkOutput("block_err", block_err, pipe2.be);
    checkOutput("block_err_bits", block_err_bits, pipe2.bits);
    checkOutput("prbs_locked", prbs_locked, pipe2.lk);
    checkOutput("err_count", err_count, pipe2.cnt);
    checkOutput("err_count_sat", err_count_sat, pipe2.sat);
    obs_bits_sum += int'(block_err_bits);
    if (block_err) err_pulses++;
    if (!prev_lk && prbs_locked && rise_idx < 0) rise_idx = pipe2.idx;
    if (prev_lk && !prbs_locked && fall_idx < 0) fall_idx = pipe2.idx;
    prev_lk = prbs_locked;
  endtask

  // Helpers: a clean pattern block, a junk invalid cycle, a block with flipped bits
  task automatic sendClean();
    logic [65:0] l;
    genBlock(l);
    applyStimulus(1'b1, 1'b1, 1'b0, l);
  endtask

  task automatic sendIdle(input logic en, input logic clr);
    logic [65:0] l;
    l[65:34] = $urandom; l[33:2] = $urandom; l[1:0] = 2'($urandom_range(3, 0));
    applyStimulus(1'b0, en, clr, l);
  endtask

  task automatic sendFlipped(input int pos, input logic clr);
    logic [65:0] l;
    genBlock(l);
    l[pos] = ~l[pos];
    applyStimulus(1'b1, 1'b1, clr, l);
  endtask

  task automatic resetPhaseCounters();
    blk_idx = 0; rise_idx = -1; fall_idx = -1; err_pulses = 0; obs_bits_sum = 0;
  endtask

  // Main sequence: reset, lock, single error, loss of lock, clear, gaps, random, reset
  initial begin
    logic [31:0] seed;
    zero_exp = '{be: 1'b0, bits: '0, lk: 1'b0, cnt: '0, sat: 1'b0, idx: 0};
    seed = 32'h5A3C_91E7;
    for (int i = 0; i < 31; i++) g_q.push_back(seed[i]);
    rx_rst = 1'b1; cfg_enable = 1'b1; rx_valid = 1'b0; err_clear = 1'b0;
    rx_data = '0; rx_hdr = '0;
    resetPhaseCounters();
    modelReset();
    repeat (3) @(posedge rx_clk);
    #1;
    checkOutput("rst_locked", prbs_locked, 0);
    checkOutput("rst_block_err", block_err, 0);
    checkOutput("rst_err_bits", block_err_bits, 0);
    checkOutput("rst_err_count", err_count, 0);
    checkOutput("rst_sat", err_count_sat, 0);
    rx_rst = 1'b0;
    repeat (4) sendIdle(1'b1, 1'b0);

    $display("[TB] clean lock");
    resetPhaseCounters();
    repeat (80) sendClean();
    repeat (2) sendIdle(1'b1, 1'b0);
    checkOutput("lock_block_index", rise_idx, 65);
    checkOutput("lock_err_pulses", err_pulses, 0);
    checkOutput("lock_err_count", err_count, 0);
    checkOutput("lock_state", prbs_locked, 1);

    $display("[TB] single error");
    resetPhaseCounters();
    sendFlipped(12, 1'b0);
    repeat (5) sendClean();
    repeat (2) sendIdle(1'b1, 1'b0);
    checkOutput("single_err_bits", obs_bits_sum, 3);
    checkOutput("single_err_count", err_count, 3);
    checkOutput("single_locked", prbs_locked, 1);
    checkOutput("single_no_unlock", fall_idx, -1);

    $display("[TB] loss of lock");
    resetPhaseCounters();
    repeat (24) applyStimulus(1'b1, 1'b1, 1'b0, 66'd0);
    repeat (2) sendIdle(1'b1, 1'b0);
    checkOutput("unlock_block_index", fall_idx, 16);
    checkOutput("unlock_err_pulses", err_pulses, 24);
    checkOutput("unlock_err_count", err_count, CNT_MAX);
    checkOutput("unlock_sat", err_count_sat, 1);

    $display("[TB] relock and clear with error");
    resetPhaseCounters();
    repeat (70) sendClean();
    repeat (2) sendIdle(1'b1, 1'b0);
    checkOutput("relock_block_index", rise_idx, 65);
    checkOutput("relock_sat_held", err_count_sat, 1);
    sendFlipped(12, 1'b1);
    repeat (3) sendClean();
    repeat (2) sendIdle(1'b1, 1'b0);
    checkOutput("clear_err_count", err_count, 3);
    checkOutput("clear_sat", err_count_sat, 0);

    $display("[TB] enable drop and gapped relock");
    sendIdle(1'b0, 1'b0);
    repeat (2) sendIdle(1'b1, 1'b0);
    checkOutput("disable_locked", prbs_locked, 0);
    checkOutput("disable_err_count", err_count, 3);
    resetPhaseCounters();
    for (int i = 0; i < 140; i++) begin
      if (i % 2 == 0) sendClean();
      else sendIdle(1'b1, 1'b0);
    end
    repeat (2) sendIdle(1'b1, 1'b0);
    checkOutput("gap_lock_index", rise_idx, 65);
    checkOutput("gap_err_pulses", err_pulses, 0);
    checkOutput("gap_err_count", err_count, 3);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      logic [65:0] l;
      logic v, en, clr;
      v   = ($urandom_range(3, 0) != 0);
      en  = ($urandom_range(49, 0) != 0);
      clr = ($urandom_range(39, 0) == 0);
      if (v) begin
        genBlock(l);
        if ($urandom_range(9, 0) == 0) begin
          for (int k = 0; k < int'($urandom_range(3, 1)); k++) begin
            int p;
            p = int'($urandom_range(65, 0));
            l[p] = ~l[p];
          end
        end
      end else begin
        l[65:34] = $urandom; l[33:2] = $urandom; l[1:0] = 2'($urandom_range(3, 0));
      end
      applyStimulus(v, en, clr, l);
    end

    $display("[TB] reset mid-operation");
    resetPhaseCounters();
    repeat (70) sendClean();
    sendFlipped(30, 1'b0);
    sendClean();
    #3;
    rx_rst = 1'b1;
    #1;
    checkOutput("async_rst_locked", prbs_locked, 0);
    checkOutput("async_rst_block_err", block_err, 0);
    checkOutput("async_rst_err_bits", block_err_bits, 0);
    checkOutput("async_rst_err_count", err_count, 0);
    checkOutput("async_rst_sat", err_count_sat, 0);
    modelReset();
    @(posedge rx_clk); #1;
    rx_rst = 1'b0;
    repeat (4) sendIdle(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
